decode_pattern_encoder: RTL and testbench

- Reverse-lookup (encoder) companion to the 3-bit address decoder.
- Accepts an 8-bit decode pattern and sequentially scans the fixed 8-entry address→pattern table, one entry per clock.
- Returns the lowest matching address, a hit flag, a match count and an ambiguity flag.
- Sits on the readback/diagnostic path; valid/ready handshake on both sides.

---
 rtl/decode_pattern_encoder.sv | 132 +++++++++++++
 tb/tb_decode_pattern_encoder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/decode_pattern_encoder.sv
// decode_pattern_encoder
// Reverse lookup for the 3-bit address decoder: scans the fixed 8-entry
// address->pattern table one entry per clock and reports the lowest
// matching address, a hit flag, the match count and an ambiguity flag.
//
// state | meaning
// IDLE  | ready for a request, no result held
// SCAN  | comparing table[index] against the captured pattern, 8 edges
// DONE  | result registered and presented until out_ready

module decode_pattern_encoder #(
  parameter bit ZERO_IS_VALID = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_pattern,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_address,
  output logic       out_hit,
  output logic       out_multi,
  output logic [3:0] out_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q;
  logic [7:0] pattern_q;
  logic [2:0] index_q;
  logic [3:0] count_q;
  logic [2:0] first_q;

  logic       out_valid_q;
  logic [2:0] out_address_q;
  logic       out_hit_q;
  logic       out_multi_q;
  logic [3:0] out_count_q;

  logic [7:0] entry;
  logic       match;
  logic [3:0] count_d;
  logic [2:0] first_d;

  // Hard-coded address->pattern table, mirrors the decoder's mapping.
  function automatic logic [7:0] table_entry(input logic [2:0] addr);
    case (addr)
      3'd0:    table_entry = 8'h00;
      3'd1:    table_entry = 8'h0B;
      3'd2:    table_entry = 8'h2C;
      3'd3:    table_entry = 8'h00;
      3'd4:    table_entry = 8'h00;
      3'd5:    table_entry = 8'h58;
      3'd6:    table_entry = 8'h58;
      default: table_entry = 8'h2A;
    endcase
  endfunction

  // Compare the current table entry and form the updated count / first match.
  always_comb begin
    entry   = table_entry(index_q);
    match   = (entry == pattern_q) && (ZERO_IS_VALID || (entry != 8'h00));
    count_d = count_q + {3'b000, match};
    first_d = (match && (count_q == 4'd0)) ? index_q : first_q;
  end

  // Request/scan/result sequencer with registered result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pattern_q     <= 8'h00;
      index_q       <= 3'd0;
      count_q       <= 4'd0;
      first_q       <= 3'd0;
      out_valid_q   <= 1'b0;
      out_address_q <= 3'd0;
      out_hit_q     <= 1'b0;
      out_multi_q   <= 1'b0;
      out_count_q   <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          out_valid_q <= 1'b0;
          if (in_valid) begin
            pattern_q <= in_pattern;
            index_q   <= 3'd0;
            count_q   <= 4'd0;
            first_q   <= 3'd0;
            state_q   <= SCAN;
          end
        end
        SCAN: begin
          count_q <= count_d;
          first_q <= first_d;
          index_q <= index_q + 3'd1;
          if (index_q == 3'd7) begin
            state_q       <= DONE;
            out_valid_q   <= 1'b1;
            out_address_q <= (count_d != 4'd0) ? first_d : 3'd0;
            out_hit_q     <= (count_d != 4'd0);
            out_multi_q   <= (count_d > 4'd1);
            out_count_q   <= count_d;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  // Ready only when idle and out of reset; low combinationally during reset.
  assign in_ready    = rst_n && (state_q == IDLE);
  assign out_valid   = out_valid_q;
  assign out_address = out_address_q;
  assign out_hit     = out_hit_q;
  assign out_multi   = out_multi_q;
  assign out_count   = out_count_q;

endmodule

// File: tb/tb_decode_pattern_encoder.sv
// Bench for decode_pattern_encoder: two instances (zero patterns valid /
// invalid) driven with the same stimulus, compared against a table model.

module tb_decode_pattern_encoder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_pattern;
  logic       out_ready;

  logic       in_ready_a, out_valid_a, out_hit_a, out_multi_a;
  logic [2:0] out_address_a;
  logic [3:0] out_count_a;
  logic       in_ready_b, out_valid_b, out_hit_b, out_multi_b;
  logic [2:0] out_address_b;
  logic [3:0] out_count_b;

  int errors = 0;
  int checks = 0;

  localparam logic [7:0] TBL [8] = '{8'h00, 8'h0B, 8'h2C, 8'h00,
                                     8'h00, 8'h58, 8'h58, 8'h2A};

  decode_pattern_encoder #(.ZERO_IS_VALID(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_pattern(in_pattern), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_address(out_address_a), .out_hit(out_hit_a), .out_multi(out_multi_a),
    .out_count(out_count_a)
  );

  decode_pattern_encoder #(.ZERO_IS_VALID(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_pattern(in_pattern), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_address(out_address_b), .out_hit(out_hit_b), .out_multi(out_multi_b),
    .out_count(out_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference lookup: count all matching entries, remember the lowest address.
  task automatic ref_model(input logic [7:0] p, input bit ziv,
                           output logic [2:0] addr, output logic hit,
                           output logic multi, output logic [3:0] cnt);
    int n;
    int lowest;
    n = 0;
    lowest = 0;
    if (ziv || p != 8'h00) begin
      for (int i = 7; i >= 0; i--) begin
        if (TBL[i] == p) begin
          n++;
          lowest = i;
        end
      end
    end
    cnt   = 4'(n);
    hit   = (n > 0);
    multi = (n >= 2);
    addr  = (n > 0) ? 3'(lowest) : 3'd0;
  endtask

  task automatic run_txn(input logic [7:0] p, input int hold);
    logic [2:0] ea, eb;
    logic       eha, ehb, ema, emb;
    logic [3:0] eca, ecb;
    int         edges;
    ref_model(p, 1'b1, ea, eha, ema, eca);
    ref_model(p, 1'b0, eb, ehb, emb, ecb);
    out_ready  = 1'b0;
    in_pattern = p;
    in_valid   = 1'b1;
    chk("in_ready_idle", in_ready_a, 1'b1);
    tick();
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid_a && edges < 20) begin
      in_valid   = 1'($urandom_range(0, 1));
      in_pattern = 8'($urandom);
      tick();
      edges++;
    end
    chk("latency", edges, 8);
    chk("valid_b", out_valid_b, 1'b1);
    chk("in_ready_done", in_ready_a, 1'b0);
    chk("addr_a", out_address_a, ea);
    chk("hit_a", out_hit_a, eha);
    chk("multi_a", out_multi_a, ema);
    chk("count_a", out_count_a, eca);
    chk("addr_b", out_address_b, eb);
    chk("hit_b", out_hit_b, ehb);
    chk("multi_b", out_multi_b, emb);
    chk("count_b", out_count_b, ecb);
    for (int h = 0; h < hold; h++) begin
      in_valid   = 1'($urandom_range(0, 1));
      in_pattern = 8'($urandom);
      tick();
      chk("hold_valid", out_valid_a, 1'b1);
      chk("hold_addr", out_address_a, ea);
      chk("hold_count", out_count_a, eca);
      chk("hold_count_b", out_count_b, ecb);
      chk("hold_in_ready", in_ready_a, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("drop_valid", out_valid_a, 1'b0);
    chk("ready_after", in_ready_a, 1'b1);
    out_ready = 1'b0;
    tick();
    chk("no_second", out_valid_a, 1'b0);
  endtask

  initial begin
    logic [7:0] p;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_pattern = 8'h00;
    out_ready  = 1'b0;
    tick();
    tick();
    chk("rst_valid", out_valid_a, 1'b0);
    chk("rst_in_ready", in_ready_a, 1'b0);
    chk("rst_addr", out_address_a, 3'd0);
    chk("rst_count", out_count_a, 4'd0);
    chk("rst_hit", out_hit_a, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", in_ready_a, 1'b1);

    run_txn(8'h0B, 0);
    run_txn(8'h58, 1);
    run_txn(8'h2A, 0);
    run_txn(8'h00, 2);
    run_txn(8'hFF, 0);
    run_txn(8'h2C, 5);

    // Reset at the 4th scan cycle abandons the request.
    in_pattern = 8'h58;
    in_valid   = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready_a, 1'b0);
    tick();
    chk("midrst_valid", out_valid_a, 1'b0);
    chk("midrst_in_ready2", in_ready_a, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("midrst_rel_ready", in_ready_a, 1'b1);
    begin
      int seen;
      seen = 0;
      repeat (12) begin
        tick();
        if (out_valid_a || out_valid_b) seen++;
      end
      chk("midrst_no_result", seen, 0);
    end
    run_txn(8'h0B, 0);

    for (int k = 0; k < 20; k++) begin
      p = ($urandom_range(0, 1) == 1) ? TBL[$urandom_range(0, 7)] : 8'($urandom);
      run_txn(p, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
